// File: rtl/serial_tx_ctrl_if.sv
// serial_tx_ctrl_if: byte handshake and serial line between character source and transmitter
interface serial_tx_ctrl_if;
    logic       load;
    logic [7:0] data_in;
    logic       ready;
    logic       tx;
    logic       charSent;
    modport master(output load, data_in, input ready, tx, charSent);
    modport slave(input load, data_in, output ready, tx, charSent);
endinterface

// File: rtl/serial_tx_ctrl.sv
// serial_tx_ctrl: frames a loaded byte as start, 8 data bits LSB first, stop, each CLKS_PER_BIT clocks
module serial_tx_ctrl #(
    parameter int CLKS_PER_BIT = 16
) (
    input logic             clk,
    input logic             rst,
    serial_tx_ctrl_if.slave bus
);
    localparam int SW = $clog2(CLKS_PER_BIT);
    localparam logic [SW-1:0] SC_MAX = SW'(CLKS_PER_BIT - 1);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t        r_state, w_state_nxt;
    logic [SW-1:0] r_sc, w_sc_nxt;
    logic [2:0]    r_bi, w_bi_nxt;
    logic [7:0]    r_sr, w_sr_nxt;
    logic          r_char_sent, w_char_sent_nxt;
    logic          w_wrap;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_sc        <= '0;
            r_bi        <= '0;
            r_sr        <= '0;
            r_char_sent <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sc        <= w_sc_nxt;
            r_bi        <= w_bi_nxt;
            r_sr        <= w_sr_nxt;
            r_char_sent <= w_char_sent_nxt;
        end
    end
    always_comb begin
        w_wrap          = r_sc == SC_MAX;
        w_state_nxt     = r_state;
        w_sc_nxt        = (r_state == IDLE || w_wrap) ? '0 : r_sc + SW'(1);
        w_bi_nxt        = r_bi;
        w_sr_nxt        = r_sr;
        w_char_sent_nxt = 1'b0;
        case (r_state)
            IDLE: if (bus.load) begin
                w_sr_nxt    = bus.data_in;
                w_state_nxt = START;
            end
            START: if (w_wrap) w_state_nxt = DATA;
            DATA: if (w_wrap) begin
                w_sr_nxt    = {1'b0, r_sr[7:1]};
                w_bi_nxt    = r_bi + 3'd1;
                w_state_nxt = (r_bi == 3'd7) ? STOP : DATA;
            end
            STOP: if (w_wrap) begin
                w_state_nxt     = IDLE;
                w_char_sent_nxt = 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end
    assign bus.ready    = r_state == IDLE;
    assign bus.tx       = (r_state == DATA) ? r_sr[0] : (r_state != START);
    assign bus.charSent = r_char_sent;
endmodule

// File: doc/serial_tx_ctrl.md
# serial_tx_ctrl

Transmit-side controller for the lab serial link. It accepts a parallel byte through a load/ready handshake and sequences the bit-sampling and bit-identification counting needed to frame it onto the serial line. Each frame is one start bit, 8 data bits sent LSB first, and one stop bit, with every bit held for `CLKS_PER_BIT` clocks. At the end of each frame it raises a one-cycle `charSent` pulse for the upstream character source.

## Interface
- `CLKS_PER_BIT`, default 16: clocks per serial bit; legal range 2..256.
- `clk` input, 1 bit: system clock; all state changes on the rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `load` input, 1 bit: request to transmit `data_in`; sampled only when `ready`=1.
- `data_in` input, 8 bits: byte to send; captured on the accepting edge.
- `ready` output, 1 bit: high in IDLE; the controller can accept a byte.
- `tx` output, 1 bit: serial line; idles high.
- `charSent` output, 1 bit: one-cycle pulse marking frame completion.

## Operation
- States and transitions:
  - IDLE → START when `load`=1 at a rising edge.
  - START → DATA.
  - DATA → STOP.
  - STOP → IDLE.
- Registers:
  - Sample counter `sc`: width `$clog2(CLKS_PER_BIT)`, counts 0..`CLKS_PER_BIT`-1.
  - Bit index `bi`: 3 bits, counts 0..7.
  - Shift register `sr`: 8 bits.
- IDLE:
  - `tx`=1, `ready`=1, `sc`=0, `bi`=0.
  - `load`=1 at an edge captures `data_in` into `sr` and enters START.
- START:
  - `tx`=0.
  - `sc` increments each cycle.
  - When `sc`=`CLKS_PER_BIT`-1: `sc` wraps to 0 and the state goes to DATA.
- DATA:
  - `tx`=`sr[0]`.
  - On `sc` wrap: `sr` shifts right by one and `bi` increments.
  - When `sc` wraps with `bi`=7: `bi`→0 and the state goes to STOP.
- STOP:
  - `tx`=1.
  - On `sc` wrap: state goes to IDLE and `charSent`=1 for exactly the first IDLE cycle.
- `load` while `ready`=0 is ignored. `data_in` is not captured and the in-flight frame is unaffected.
- `data_in` changes after the accepting edge have no effect on the frame.
- All outputs are registered or decoded from the state alone. None depend combinationally on `load` or `data_in`.
- Reset, including mid-frame:
  - Immediately, without waiting for a clock edge: IDLE, `tx`=1, `ready`=1, `charSent`=0, `sc`=0, `bi`=0, `sr`=0.
  - A partially sent frame is abandoned, not resumed.

## Timing
- Let edge E0 be the rising edge that accepts a byte (`load`=1, `ready`=1).
- After E0:
  - `ready`=0 and `tx`=0 (start bit).
  - `tx` holds each bit for exactly `CLKS_PER_BIT` cycles.
- Bit k (0..7) is driven from E0+(k+1)·N to E0+(k+2)·N, where N = `CLKS_PER_BIT`.
- The stop bit is driven from E0+9N to E0+10N.
- After E0+10N: `ready`=1 and `charSent`=1 for one cycle.
- Back-to-back frames:
  - A `load` held high through that cycle is accepted at E0+10N+1.
  - The minimum frame period is therefore 10N+1 clocks.
  - The line stays high for one idle cycle between frames.
- Reset values of all outputs: `ready`=1, `tx`=1, `charSent`=0.

## Test plan
- **Reset**: assert `rst` between edges. Required: `tx`=1, `ready`=1, `charSent`=0 immediately, and held through 5 clocks with `load`=0.
- **Single frame**: N=16, load `data_in`=8'hA5. Required on `tx`, 16 cycles each: 0, 1,0,1,0,0,1,0,1, 1. Then `charSent` pulses once at E0+160 and `ready`=1.
- **Busy load ignored**: N=16, send 8'h3C, then pulse `load` with 8'hFF at E0+40. Required: the frame still carries 8'h3C, and no second frame follows.
- **Back-to-back**: N=4, hold `load`=1 with 8'h01 then 8'h80. Required:
  - Second start bit begins at E0+41.
  - Exactly one idle-high cycle between the frames.
  - Two `charSent` pulses, 41 cycles apart.
- **Reset mid-frame**: N=16, send 8'h55 and assert `rst` at E0+70 for 2 cycles. Required: `tx`=1 and `ready`=1 at once. A new load of 8'h0F afterwards produces a complete, correct frame.
- **Minimum N**: N=2, send 8'h00. Required: `tx` low for 18 cycles, high for 2, and `charSent` at E0+20.
